// File: rtl/prm_edge_chk_sched_pkg.sv
// Shared types and constants for the PRM edge-checker sequencer.
// The FSM state type and the result word-count helper live here.
package prm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int DEFAULT_CODE_W = 15;
  localparam int DEFAULT_WORD_W = 32;

  // Number of result words needed to carry one mask bit per edge.
  function automatic int num_words(input int num_edges, input int word_w);
    return (num_edges + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/prm_edge_chk_sched_if.sv
// Result-word stream between the sequencer (master) and its consumer (slave).
interface prm_edge_chk_sched_if #(
  parameter int WORD_W = 32,
  parameter int EDGE_W = 10
);
  logic              res_valid_o;
  logic              res_ready_i;
  logic [WORD_W-1:0] res_word_o;
  logic [EDGE_W-1:0] res_base_o;
  logic              res_last_o;

  modport master (
    output res_valid_o,
    output res_word_o,
    output res_base_o,
    output res_last_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o,
    input  res_word_o,
    input  res_base_o,
    input  res_last_o,
    output res_ready_i
  );
endinterface

// File: rtl/prm_edge_chk_sched_mask_packer.sv
// Packs one edge-mask bit per cycle into a result word, tracking the word's
// base edge, whether it is the final word, and the running blocked-edge count.
module prm_mask_packer
  import prm_sched_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int EDGE_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              clear,
  input  logic              bit_valid,
  input  logic [EDGE_W-1:0] bit_idx,
  input  logic              bit_val,
  output logic [WORD_W-1:0] word,
  output logic [EDGE_W-1:0] base,
  output logic              last,
  output logic [EDGE_W:0]   cnt
);

  localparam int BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int NUM_WORDS = num_words(NUM_EDGES, WORD_W);

  logic [31:0]       idx_ext;
  logic [BIT_W-1:0]  bit_pos;
  logic [WORD_W-1:0] word_reg;
  logic [EDGE_W-1:0] base_reg;
  logic              last_reg;
  logic [EDGE_W:0]   cnt_reg;

  assign idx_ext = 32'(bit_idx);
  assign bit_pos = BIT_W'(idx_ext % 32'(WORD_W));

  // Each word bit has its own write strobe, so a fresh word starts all-zero
  // and bits beyond the last edge of a partial word stay zero.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst || restart || clear) begin
          word_reg[gi] <= 1'b0;
        end else if (bit_valid && (bit_pos == BIT_W'(gi))) begin
          word_reg[gi] <= bit_val;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      base_reg <= '0;
      last_reg <= 1'b0;
    end else if (bit_valid) begin
      base_reg <= EDGE_W'(idx_ext - (idx_ext % 32'(WORD_W)));
      last_reg <= (idx_ext / 32'(WORD_W)) == 32'(NUM_WORDS - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_reg <= '0;
    end else if (bit_valid && bit_val) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign word = word_reg;
  assign base = base_reg;
  assign last = last_reg;
  assign cnt  = cnt_reg;

endmodule

// File: rtl/prm_edge_chk_sched.sv
// PRM edge-collision sweep sequencer: latches an obstacle code, walks every
// edge through the checker mux one per cycle and streams packed mask words.
module prm_edge_chk_sched
  import prm_sched_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int CODE_W    = DEFAULT_CODE_W,
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int EDGE_W    = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CODE_W-1:0]    obs_code_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [EDGE_W-1:0]    chk_edge_o,
  output logic [CODE_W-1:0]    chk_code_o,
  input  logic                 chk_mask_i,
  prm_edge_chk_sched_if.master res,
  output logic [EDGE_W:0]      blocked_cnt_o
);

  sched_state_t      state_reg, state_next;
  logic [EDGE_W-1:0] edge_reg, edge_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic              restart, clear, bit_valid;
  logic [31:0]       edge_ext;
  logic              word_end, edge_last;

  assign edge_ext  = 32'(edge_reg);
  assign word_end  = (edge_ext % 32'(WORD_W)) == 32'(WORD_W - 1);
  assign edge_last = (edge_reg == EDGE_W'(NUM_EDGES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      edge_reg  <= '0;
      code_reg  <= '0;
    end else begin
      state_reg <= state_next;
      edge_reg  <= edge_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    edge_next  = edge_reg;
    code_next  = code_reg;
    restart    = 1'b0;
    clear      = 1'b0;
    bit_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          code_next  = obs_code_i;
          edge_next  = '0;
          restart    = 1'b1;
          state_next = SWEEP;
        end
      end
      SWEEP: begin
        bit_valid = 1'b1;
        if (word_end || edge_last) begin
          state_next = EMIT;
        end else begin
          edge_next = edge_reg + 1'b1;
        end
      end
      EMIT: begin
        if (res.res_ready_i) begin
          if (edge_last) begin
            state_next = DONE;
          end else begin
            edge_next  = edge_reg + 1'b1;
            clear      = 1'b1;
            state_next = SWEEP;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // An abort discards the edge presented in this cycle and keeps the
    // partial blocked count visible.
    if (abort_i && (state_reg != IDLE)) begin
      state_next = IDLE;
      edge_next  = edge_reg;
      bit_valid  = 1'b0;
      clear      = 1'b0;
    end
  end

  assign busy_o          = (state_reg != IDLE);
  assign done_o          = (state_reg == DONE);
  assign res.res_valid_o = (state_reg == EMIT);
  assign chk_edge_o      = (state_reg == SWEEP) ? edge_reg : '0;
  assign chk_code_o      = (state_reg == SWEEP) ? code_reg : '0;

  prm_mask_packer #(
    .NUM_EDGES (NUM_EDGES),
    .WORD_W    (WORD_W),
    .EDGE_W    (EDGE_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .clear     (clear),
    .bit_valid (bit_valid),
    .bit_idx   (edge_reg),
    .bit_val   (chk_mask_i),
    .word      (res.res_word_o),
    .base      (res.res_base_o),
    .last      (res.res_last_o),
    .cnt       (blocked_cnt_o)
  );

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Randomized bench for prm_edge_chk_sched: a 40-edge and a default 1024-edge
// instance are swept against a mask table and a word/latency reference model.
module tb_prm_edge_chk_sched;

  localparam int NA = 40;
  localparam int NB = 1024;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s, abort_s, ready_s;
  logic [14:0] code_s;
  int          sel;
  logic        mask_tab [0:1023];

  int tests_run = 0;
  int tests_failed = 0;

  // DUT A: 40 edges
  prm_edge_chk_sched_if #(.WORD_W(WW), .EDGE_W(6)) if_a ();
  logic        busy_a, done_a, mask_a;
  logic [5:0]  edge_a;
  logic [14:0] code_a;
  logic [6:0]  cnt_a;

  // DUT B: default 1024 edges
  prm_edge_chk_sched_if #(.WORD_W(WW), .EDGE_W(10)) if_b ();
  logic        busy_b, done_b, mask_b;
  logic [9:0]  edge_b;
  logic [14:0] code_b;
  logic [10:0] cnt_b;

  assign mask_a = mask_tab[edge_a];
  assign mask_b = mask_tab[edge_b];
  assign if_a.res_ready_i = (sel == 0) ? ready_s : 1'b0;
  assign if_b.res_ready_i = (sel == 1) ? ready_s : 1'b0;

  prm_edge_chk_sched #(.NUM_EDGES(NA), .EDGE_W(6)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .start_i       ((sel == 0) ? start_s : 1'b0),
    .abort_i       ((sel == 0) ? abort_s : 1'b0),
    .obs_code_i    (code_s),
    .busy_o        (busy_a),
    .done_o        (done_a),
    .chk_edge_o    (edge_a),
    .chk_code_o    (code_a),
    .chk_mask_i    (mask_a),
    .res           (if_a),
    .blocked_cnt_o (cnt_a)
  );

  prm_edge_chk_sched dut_b (
    .clk           (clk),
    .rst           (rst),
    .start_i       ((sel == 1) ? start_s : 1'b0),
    .abort_i       ((sel == 1) ? abort_s : 1'b0),
    .obs_code_i    (code_s),
    .busy_o        (busy_b),
    .done_o        (done_b),
    .chk_edge_o    (edge_b),
    .chk_code_o    (code_b),
    .chk_mask_i    (mask_b),
    .res           (if_b),
    .blocked_cnt_o (cnt_b)
  );

  logic        o_busy, o_done, o_valid, o_last;
  logic [31:0] o_edge, o_code, o_word, o_base, o_cnt;

  always_comb begin
    if (sel == 0) begin
      o_busy  = busy_a;
      o_done  = done_a;
      o_valid = if_a.res_valid_o;
      o_last  = if_a.res_last_o;
      o_edge  = 32'(edge_a);
      o_code  = 32'(code_a);
      o_word  = if_a.res_word_o;
      o_base  = 32'(if_a.res_base_o);
      o_cnt   = 32'(cnt_a);
    end else begin
      o_busy  = busy_b;
      o_done  = done_b;
      o_valid = if_b.res_valid_o;
      o_last  = if_b.res_last_o;
      o_edge  = 32'(edge_b);
      o_code  = 32'(code_b);
      o_word  = if_b.res_word_o;
      o_base  = 32'(if_b.res_base_o);
      o_cnt   = 32'(cnt_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: word k carries mask bits of edges k*WW .. k*WW+WW-1, zero past n.
  function automatic logic [31:0] exp_word(input int k, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < WW; i++) begin
      if (k * WW + i < n) w[i] = mask_tab[k * WW + i];
    end
    return w;
  endfunction

  function automatic int mask_sum(input int upto);
    int s;
    s = 0;
    for (int i = 0; i < upto; i++) s += int'(mask_tab[i]);
    return s;
  endfunction

  task automatic fill_mask(input int mode);
    for (int i = 0; i < 1024; i++) begin
      case (mode)
        0:       mask_tab[i] = i[0];
        1:       mask_tab[i] = 1'b1;
        default: mask_tab[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_last"}, 64'(o_last), 64'd0);
    check({tag, "_edge"}, 64'(o_edge), 64'd0);
    check({tag, "_code"}, 64'(o_code), 64'd0);
    check({tag, "_word"}, 64'(o_word), 64'd0);
    check({tag, "_base"}, 64'(o_base), 64'd0);
    check({tag, "_cnt"}, 64'(o_cnt), 64'd0);
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 low for the first 5 cycles of word 0.
  task automatic run_sweep(input int s, input int n, input logic [14:0] code,
                           input int rdy_mode, input int abort_at,
                           input int mid_start, input int rst_in_emit);
    int cyc, widx, stalls, exp_edge, nw, done_seen;
    nw = (n + WW - 1) / WW;
    widx = 0; stalls = 0; exp_edge = 0; done_seen = 0;
    sel = s;
    @(posedge clk); #1;
    start_s = 1'b1;
    code_s  = code;
    ready_s = 1'b1;
    @(negedge clk);
    check("start_cycle_busy", 64'(o_busy), 64'd0);
    cyc = 0;
    @(posedge clk); #1;
    start_s = 1'b0;
    code_s  = 15'($urandom) ^ code ^ 15'h1;
    cyc = 1;
    while (!done_seen && cyc < 5000) begin
      @(negedge clk);
      check("busy", 64'(o_busy), 64'd1);
      if (o_valid) begin
        check("word", 64'(o_word), 64'(exp_word(widx, n)));
        check("base", 64'(o_base), 64'(widx * WW));
        check("last", 64'(o_last), 64'(widx == nw - 1));
        if (rst_in_emit != 0 && !ready_s) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          @(negedge clk);
          check_zero("after_rst");
          @(negedge clk);
          check_zero("after_rst_hold");
          $display("[TB] sweep sel=%0d reset in EMIT at word %0d", s, widx);
          return;
        end
        if (ready_s) widx++;
        else stalls++;
      end else if (o_done) begin
        done_seen = 1;
        check("done_cycle", 64'(cyc), 64'(1 + n + nw + stalls));
        check("words_seen", 64'(widx), 64'(nw));
        check("edges_seen", 64'(exp_edge), 64'(n));
        check("blocked_cnt", 64'(o_cnt), 64'(mask_sum(n)));
      end else begin
        check("chk_edge", 64'(o_edge), 64'(exp_edge));
        check("chk_code", 64'(o_code), 64'(code));
        if (exp_edge == abort_at) begin
          abort_s = 1'b1;
          @(posedge clk); #1;
          abort_s = 1'b0;
          @(negedge clk);
          check("abort_busy", 64'(o_busy), 64'd0);
          check("abort_valid", 64'(o_valid), 64'd0);
          check("abort_done", 64'(o_done), 64'd0);
          check("abort_cnt", 64'(o_cnt), 64'(mask_sum(abort_at)));
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_quiet", 64'({o_busy, o_valid, o_done}), 64'd0);
          end
          $display("[TB] sweep sel=%0d aborted at edge %0d", s, abort_at);
          return;
        end
        exp_edge++;
      end
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       ready_s = 1'b1;
        1:       ready_s = ($urandom_range(0, 3) != 0);
        default: ready_s = !(widx == 0 && stalls < 5);
      endcase
      start_s = (cyc == mid_start);
      if (cyc == mid_start) code_s = ~code;
    end
    if (!done_seen) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    @(posedge clk); #1;
    ready_s = 1'b1;
    @(negedge clk);
    check("post_done_busy", 64'(o_busy), 64'd0);
    check("post_done_pulse", 64'(o_done), 64'd0);
    check("post_done_cnt", 64'(o_cnt), 64'(mask_sum(n)));
    $display("[TB] sweep sel=%0d n=%0d code=%h words=%0d stalls=%0d done@%0d cnt=%0d",
             s, n, code, widx, stalls, cyc, o_cnt);
  endtask

  initial begin
    rst = 1'b1;
    start_s = 1'b0;
    abort_s = 1'b0;
    ready_s = 1'b0;
    code_s  = '0;
    sel = 0;
    fill_mask(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset_a");
    sel = 1;
    #1;
    check_zero("reset_b");

    // Odd edges blocked, fixed code, always ready
    fill_mask(0);
    run_sweep(0, NA, 15'h1A5C, 0, -1, -1, 0);
    // Default size, all blocked
    fill_mask(1);
    run_sweep(1, NB, 15'($urandom), 0, -1, -1, 0);
    // Backpressure on word 0
    fill_mask(0);
    run_sweep(0, NA, 15'h1A5C, 2, -1, -1, 0);
    // Abort at edge 10, then a clean random sweep
    run_sweep(0, NA, 15'h1A5C, 0, 10, -1, 0);
    fill_mask(2);
    run_sweep(0, NA, 15'($urandom), 0, -1, -1, 0);
    // Start pulses while busy are ignored
    fill_mask(0);
    run_sweep(0, NA, 15'h1A5C, 0, -1, 5, 0);
    run_sweep(0, NA, 15'h1A5C, 0, -1, 33, 0);
    // Reset while stalled in EMIT, then a normal sweep
    run_sweep(0, NA, 15'h1A5C, 2, -1, -1, 1);
    run_sweep(0, NA, 15'h1A5C, 0, -1, -1, 0);
    // Random masks, codes and backpressure
    for (int r = 0; r < 6; r++) begin
      fill_mask(2);
      run_sweep(0, NA, 15'($urandom), 1, -1, int'($urandom_range(2, 40)), 0);
    end
    fill_mask(2);
    run_sweep(1, NB, 15'($urandom), 1, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
